// File: rtl/icache_fill_responder_pkg.sv
// Shared constants and types for the instruction-cache fill responder.
// Bus tag encoding and line geometry live here so the bench and RTL agree.
package icache_fill_responder_pkg;

  localparam int unsigned LINE_BYTES = 64;
  localparam int unsigned BEATS      = 8;
  localparam int unsigned LINE_W     = LINE_BYTES * 8;
  localparam int unsigned OFF_W      = $clog2(LINE_BYTES);

  localparam logic [3:0]  READ       = 4'h1;
  localparam logic        MEMORY     = 1'b1;
  localparam logic [12:0] RD_MEM_TAG = {READ, MEMORY, 8'b0};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    REQ    = 3'd2,
    FILL   = 3'd3,
    RESP   = 3'd4
  } icache_state_t;

endpackage

// File: rtl/icache_fill_responder_if.sv
// Fetch-side and system-bus signals of the instruction-cache responder.
// slave = the cache; master = fetch unit plus bus (the environment).
interface icache_fill_responder_if;

  logic                                        ic_enable;
  logic [63:0]                                 iaddr;
  logic [icache_fill_responder_pkg::LINE_W-1:0] idata;
  logic                                        ic_done;

  logic                                        bus_reqcyc;
  logic [63:0]                                 bus_req;
  logic [12:0]                                 bus_reqtag;
  logic                                        bus_reqack;
  logic                                        bus_respcyc;
  logic [63:0]                                 bus_resp;
  logic                                        bus_respack;

  modport slave (
    input  ic_enable, iaddr, bus_reqack, bus_respcyc, bus_resp,
    output idata, ic_done, bus_reqcyc, bus_req, bus_reqtag, bus_respack
  );

  modport master (
    output ic_enable, iaddr, bus_reqack, bus_respcyc, bus_resp,
    input  idata, ic_done, bus_reqcyc, bus_req, bus_reqtag, bus_respack
  );

endinterface

// File: rtl/icache_fill_responder_array.sv
// Direct-mapped tag/valid/data store: one synchronous read port, one write port.
// Only the valid vector is reset; tags and data are don't-care until valid.
module icache_fill_responder_array
  import icache_fill_responder_pkg::*;
#(
  parameter int unsigned SETS  = 64,
  parameter int unsigned TAG_W = 52
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rd_en_i,
  input  logic [$clog2(SETS)-1:0]  rd_idx_i,
  output logic                     rd_valid_o,
  output logic [TAG_W-1:0]         rd_tag_o,
  output logic [LINE_W-1:0]        rd_data_o,
  input  logic                     wr_en_i,
  input  logic [$clog2(SETS)-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]         wr_tag_i,
  input  logic [LINE_W-1:0]        wr_data_i
);

  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [LINE_W-1:0] data_mem [SETS];
  logic              rd_valid_q;
  logic [TAG_W-1:0]  rd_tag_q;
  logic [LINE_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_en_i) valid_q[wr_idx_i] <= 1'b1;
      if (rd_en_i) rd_valid_q <= valid_q[rd_idx_i];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_mem[wr_idx_i]  <= wr_tag_i;
      data_mem[wr_idx_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_tag_q  <= tag_mem[rd_idx_i];
      rd_data_q <= data_mem[rd_idx_i];
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_tag_o   = rd_tag_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/icache_fill_responder.sv
// Instruction-cache responder: hits return the stored line, misses fetch
// eight 64-bit beats over the system bus, install the line, then answer.
module icache_fill_responder
  import icache_fill_responder_pkg::*;
#(
  parameter int unsigned SETS = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  icache_fill_responder_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 64 - OFF_W - IDX_W;

  icache_state_t     state_q, state_d;
  logic [63:0]       addr_q, addr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [LINE_W-1:0] fill_q, fill_d, beat_line;
  logic [LINE_W-1:0] idata_q, idata_d;
  logic              done_q, done_d;
  logic              reqcyc_q, reqcyc_d;
  logic [63:0]       req_q, req_d;
  logic              accept, hit, wr_en;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_data;
  logic              unused_offset;

  assign unused_offset = ^bus.iaddr[OFF_W-1:0];

  // RESP is the ic_done cycle, so it accepts a new fetch exactly like IDLE.
  assign accept = bus.ic_enable && (state_q == IDLE || state_q == RESP);
  assign hit    = rd_valid && (rd_tag == addr_q[63 -: TAG_W]);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    idata_d   = '0;
    done_d    = 1'b0;
    reqcyc_d  = reqcyc_q;
    req_d     = req_q;
    wr_en     = 1'b0;
    beat_line = fill_q;
    beat_line[{cnt_q, 6'b0} +: 64] = bus.bus_resp;

    if (accept) begin
      addr_d  = {bus.iaddr[63:OFF_W], {OFF_W{1'b0}}};
      state_d = LOOKUP;
    end

    unique case (state_q)
      IDLE: ;
      RESP: if (!accept) state_d = IDLE;
      LOOKUP: begin
        if (hit) begin
          idata_d = rd_data;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          reqcyc_d = 1'b1;
          req_d    = addr_q;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (bus.bus_reqack) begin
          reqcyc_d = 1'b0;
          state_d  = FILL;
          if (bus.bus_respcyc) begin
            fill_d = beat_line;
            cnt_d  = 3'd1;
          end
        end
      end
      FILL: begin
        if (bus.bus_respcyc) begin
          fill_d = beat_line;
          cnt_d  = cnt_q + 3'd1;
          // Last beat: install and answer from the merged line in the same edge.
          if (cnt_q == 3'(BEATS - 1)) begin
            wr_en   = 1'b1;
            idata_d = beat_line;
            done_d  = 1'b1;
            state_d = RESP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      idata_q  <= '0;
      done_q   <= 1'b0;
      reqcyc_q <= 1'b0;
      req_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      idata_q  <= idata_d;
      done_q   <= done_d;
      reqcyc_q <= reqcyc_d;
      req_q    <= req_d;
    end
  end

  always_ff @(posedge clk) begin
    fill_q <= fill_d;
  end

  icache_fill_responder_array #(
    .SETS  (SETS),
    .TAG_W (TAG_W)
  ) u_array (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_en_i    (accept),
    .rd_idx_i   (bus.iaddr[OFF_W +: IDX_W]),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (wr_en),
    .wr_idx_i   (addr_q[OFF_W +: IDX_W]),
    .wr_tag_i   (addr_q[63 -: TAG_W]),
    .wr_data_i  (beat_line)
  );

  assign bus.idata       = idata_q;
  assign bus.ic_done     = done_q;
  assign bus.bus_reqcyc  = reqcyc_q;
  assign bus.bus_req     = req_q;
  assign bus.bus_reqtag  = RD_MEM_TAG;
  assign bus.bus_respack = bus.bus_respcyc;

endmodule

// File: tb/tb_icache_fill_responder.sv
// Directed plus randomized bench for icache_fill_responder against a
// line-address-keyed cache model.
module tb_icache_fill_responder;
  import icache_fill_responder_pkg::*;

  localparam int unsigned SETS = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model: per set, whether it holds a line, which line address, and its bytes.
  bit           m_valid [SETS];
  logic [63:0]  m_line  [SETS];
  logic [511:0] m_data  [SETS];

  bit           chain = 1'b0;
  bit           issued = 1'b0;
  logic [63:0]  chain_addr = '0;

  icache_fill_responder_if bus ();

  icache_fill_responder #(.SETS(SETS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [63:0] addr, input int unsigned ack_delay, input bit ack_beat,
                       input int unsigned gap_pct, input bit poke, input bit fixed);
    logic [63:0]  line;
    int unsigned  idx;
    bit           is_hit;
    logic [63:0]  beats [8];
    logic [511:0] exp_line;
    int unsigned  k;
    int unsigned  gaps;
    bit           poked;
    line   = addr & ~64'h3F;
    idx    = int'(line[11:6]);
    is_hit = m_valid[idx] && (m_line[idx] == line);
    for (int i = 0; i < 8; i++) begin
      beats[i] = fixed ? 64'hC0DE_0000_0000_0000 + 64'(i) : {$urandom, $urandom};
      exp_line[i*64 +: 64] = beats[i];
    end
    if (!issued) begin
      bus.ic_enable = 1'b1;
      bus.iaddr     = addr;
      step();
    end
    issued        = 1'b0;
    bus.ic_enable = 1'b0;
    bus.iaddr     = {$urandom, $urandom};
    check("lookup_done", bus.ic_done, 1'b0);
    check("lookup_reqcyc", bus.bus_reqcyc, 1'b0);
    step();
    if (is_hit) begin
      check("hit_done", bus.ic_done, 1'b1);
      check("hit_data", bus.idata, m_data[idx]);
      check("hit_noreq", bus.bus_reqcyc, 1'b0);
    end else begin
      check("miss_done", bus.ic_done, 1'b0);
      check("req_cyc", bus.bus_reqcyc, 1'b1);
      check("req_addr", bus.bus_req, line);
      check("req_tag", bus.bus_reqtag, {READ, MEMORY, 8'b0});
      for (int d = 0; d < int'(ack_delay); d++) begin
        step();
        check("req_hold", bus.bus_reqcyc, 1'b1);
        check("req_hold_addr", bus.bus_req, line);
      end
      bus.bus_reqack = 1'b1;
      k = 0;
      if (ack_beat) begin
        bus.bus_respcyc = 1'b1;
        bus.bus_resp    = beats[0];
        k = 1;
      end
      step();
      bus.bus_reqack  = 1'b0;
      bus.bus_respcyc = 1'b0;
      check("req_drop", bus.bus_reqcyc, 1'b0);
      poked = 1'b0;
      gaps  = 0;
      while (k < 8) begin
        if ((poke && !poked) || (gaps < 3 && $urandom_range(99) < gap_pct)) begin
          bus.bus_respcyc = 1'b0;
          bus.bus_resp    = {$urandom, $urandom};
          gaps++;
          if (poke && !poked) begin
            bus.ic_enable = 1'b1;
            bus.iaddr     = {$urandom, $urandom};
            poked         = 1'b1;
          end
        end else begin
          bus.bus_respcyc = 1'b1;
          bus.bus_resp    = beats[k];
          k++;
          gaps = 0;
        end
        step();
        bus.bus_respcyc = 1'b0;
        bus.ic_enable   = 1'b0;
        if (k < 8) begin
          check("fill_nodone", bus.ic_done, 1'b0);
          check("fill_noreq", bus.bus_reqcyc, 1'b0);
        end
      end
      check("fill_done", bus.ic_done, 1'b1);
      check("fill_data", bus.idata, exp_line);
      check("resp_noreq", bus.bus_reqcyc, 1'b0);
      m_valid[idx] = 1'b1;
      m_line[idx]  = line;
      m_data[idx]  = exp_line;
    end
    if (chain) begin
      bus.ic_enable = 1'b1;
      bus.iaddr     = chain_addr;
      chain         = 1'b0;
      issued        = 1'b1;
    end
    step();
    bus.ic_enable = 1'b0;
    check("done_pulse", bus.ic_done, 1'b0);
    check("idata_clear", bus.idata, '0);
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] base;
    base = $urandom_range(1) ? 64'h0000_0000_0001_0000 : 64'h8000_0000_0001_0000;
    return base + (64'($urandom_range(1)) << 12) + (64'($urandom_range(3)) << 6)
                + 64'($urandom_range(63));
  endfunction

  initial begin
    logic [63:0] a;
    logic [63:0] nxt;
    reset_n         = 1'b0;
    bus.ic_enable   = 1'b0;
    bus.iaddr       = '0;
    bus.bus_reqack  = 1'b0;
    bus.bus_respcyc = 1'b0;
    bus.bus_resp    = '0;
    repeat (3) step();
    check("rst_done", bus.ic_done, 1'b0);
    check("rst_idata", bus.idata, '0);
    check("rst_reqcyc", bus.bus_reqcyc, 1'b0);
    check("rst_req", bus.bus_req, '0);
    reset_n = 1'b1;
    step();

    // Stray beats while idle: acked, no effect.
    bus.bus_respcyc = 1'b1;
    bus.bus_resp    = {$urandom, $urandom};
    #1;
    check("idle_respack", bus.bus_respack, 1'b1);
    step();
    step();
    bus.bus_respcyc = 1'b0;
    #1;
    check("idle_respack_low", bus.bus_respack, 1'b0);
    check("idle_nodone", bus.ic_done, 1'b0);
    check("idle_noreq", bus.bus_reqcyc, 1'b0);

    fetch(64'h1008, 0, 1'b0, 0, 1'b0, 1'b1);           // cold miss
    fetch(64'h1030, 0, 1'b0, 0, 1'b0, 1'b0);           // hit
    fetch(64'h2000, 0, 1'b0, 0, 1'b0, 1'b0);           // conflict refill
    fetch(64'h1000, 1, 1'b1, 0, 1'b0, 1'b0);           // evicted, misses again
    fetch(64'h1000, 0, 1'b0, 0, 1'b0, 1'b0);
    fetch(64'h8000_0000_0000_1000, 0, 1'b0, 0, 1'b0, 1'b0);
    fetch(64'h1000, 0, 1'b0, 0, 1'b0, 1'b0);
    fetch(64'h3440, 5, 1'b1, 40, 1'b0, 1'b0);          // delayed ack, gapped beats
    fetch(64'h4480, 2, 1'b0, 30, 1'b1, 1'b0);          // enable poked during FILL
    chain      = 1'b1;
    chain_addr = 64'h4490;
    fetch(64'h3450, 0, 1'b0, 0, 1'b0, 1'b0);           // back-to-back hits
    fetch(64'h4490, 0, 1'b0, 0, 1'b0, 1'b0);

    // Reset after beat 3; remaining beats land during and after reset.
    bus.ic_enable = 1'b1;
    bus.iaddr     = 64'h7A40;
    step();
    bus.ic_enable = 1'b0;
    step();
    check("mf_req", bus.bus_reqcyc, 1'b1);
    bus.bus_reqack = 1'b1;
    step();
    bus.bus_reqack = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if (b == 4) reset_n = 1'b0;
      if (b == 6) reset_n = 1'b1;
      bus.bus_respcyc = 1'b1;
      bus.bus_resp    = {$urandom, $urandom};
      step();
      check("mf_nodone", bus.ic_done, 1'b0);
    end
    bus.bus_respcyc = 1'b0;
    step();
    check("mf_done", bus.ic_done, 1'b0);
    check("mf_idata", bus.idata, '0);
    check("mf_reqcyc", bus.bus_reqcyc, 1'b0);
    check("mf_req_addr", bus.bus_req, '0);
    for (int s = 0; s < int'(SETS); s++) m_valid[s] = 1'b0;
    chain      = 1'b1;
    chain_addr = 64'h7A40;
    fetch(64'h7A40, 0, 1'b0, 0, 1'b0, 1'b0);           // must miss, then chained hit
    fetch(64'h7A40, 0, 1'b0, 0, 1'b0, 1'b0);
    fetch(64'h1000, 0, 1'b0, 0, 1'b0, 1'b0);

    a = rand_addr();
    for (int i = 0; i < 24; i++) begin
      nxt        = rand_addr();
      chain      = (i < 23) && ($urandom_range(1) == 1);
      chain_addr = nxt;
      fetch(a, $urandom_range(3), $urandom_range(1) == 1, $urandom_range(50),
            $urandom_range(3) == 0, 1'b0);
      a = nxt;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
